// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: debounced single-strobe operation sequencer for the hex calculator
module calc_key_sequencer #(
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       clr,
    input  logic [7:0] sw_num1,
    input  logic [7:0] sw_num2,
    input  logic [2:0] sw_func,
    output logic [7:0] num1,
    output logic [7:0] num2,
    output logic [2:0] func,
    output logic       calc_button,
    output logic       calc_rst,
    output logic       chain,
    output logic       err,
    output logic       busy,
    output logic [7:0] op_count
);
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PRESS_DB   = 3'd1;
    localparam logic [2:0] CHECK      = 3'd2;
    localparam logic [2:0] ISSUE      = 3'd3;
    localparam logic [2:0] RELEASE_DB = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_m, btn_s, clr_q;
    logic             clr_rise, illegal, cnt_done;

    assign clr_rise = clr & ~clr_q;
    assign cnt_done = cnt == CNT_MAX;
    assign illegal  = (sw_func == 3'd6) || (sw_func == 3'd7) ||
                      (((sw_func == 3'd3) || (sw_func == 3'd4)) && (sw_num2 == 8'd0));
    assign busy     = state != IDLE;

    // two-flop button synchronizer and clr edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            btn_m <= btn_raw;
            btn_s <= btn_m;
            clr_q <= clr;
        end
    end

    // press/release debounce FSM, operand latch, strobe and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            num1        <= 8'd0;
            num2        <= 8'd0;
            func        <= 3'd0;
            calc_button <= 1'b0;
            calc_rst    <= 1'b0;
            chain       <= 1'b0;
            err         <= 1'b0;
            op_count    <= 8'd0;
        end else begin
            calc_button <= 1'b0;
            calc_rst    <= clr_rise;
            if (clr_rise) begin
                state    <= RELEASE_DB;
                cnt      <= '0;
                chain    <= 1'b0;
                err      <= 1'b0;
                op_count <= 8'd0;
            end else begin
                case (state)
                    IDLE: if (btn_s) begin
                        state <= PRESS_DB;
                        cnt   <= '0;
                    end
                    PRESS_DB: begin
                        if (!btn_s)
                            state <= IDLE;
                        else if (cnt_done)
                            state <= CHECK;
                        else
                            cnt <= cnt + CNT_W'(1);
                    end
                    CHECK: begin
                        num1 <= sw_num1;
                        num2 <= sw_num2;
                        func <= sw_func;
                        if (illegal) begin
                            err   <= 1'b1;
                            state <= RELEASE_DB;
                            cnt   <= '0;
                        end else begin
                            calc_button <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        op_count <= op_count + 8'(op_count != 8'hff);
                        chain    <= 1'b1;
                        err      <= 1'b0;
                        state    <= RELEASE_DB;
                        cnt      <= '0;
                    end
                    RELEASE_DB: begin
                        if (btn_s)
                            cnt <= '0;
                        else if (cnt_done)
                            state <= IDLE;
                        else
                            cnt <= cnt + CNT_W'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: table, directed and random checks of the key sequencer
module tb_calc_key_sequencer;
    localparam int DB  = 4;
    localparam int LAT = 2 + DB + 1;

    logic       clk = 0, rst = 1, btn_raw = 0, clr = 0;
    logic [7:0] sw_num1 = 0, sw_num2 = 0;
    logic [2:0] sw_func = 0;
    logic [7:0] num1, num2, op_count;
    logic [2:0] func;
    logic       calc_button, calc_rst, chain, err, busy;

    int vectors = 0, miscompares = 0;

    logic [7:0] m_n1, m_n2, m_cnt;
    logic [2:0] m_f;
    logic       m_chain, m_err;

    typedef struct {
        logic [7:0] n1, n2;
        logic [2:0] f;
        int         ns;
        logic       err;
        int         cnt;
    } vec_t;
    vec_t tbl[10];

    calc_key_sequencer #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .clr(clr),
        .sw_num1(sw_num1), .sw_num2(sw_num2), .sw_func(sw_func),
        .num1(num1), .num2(num2), .func(func),
        .calc_button(calc_button), .calc_rst(calc_rst),
        .chain(chain), .err(err), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_n1 = 0; m_n2 = 0; m_f = 0; m_cnt = 0; m_chain = 0; m_err = 0;
    endtask

    function automatic bit legal(input logic [7:0] b, input logic [2:0] f);
        return !(f >= 6 || ((f == 3 || f == 4) && b == 0));
    endfunction

    // transaction-level effect of one press; returns the number of strobes it must produce
    function automatic int model_press(input logic [7:0] a, b, input logic [2:0] f);
        m_n1 = a; m_n2 = b; m_f = f;
        if (!legal(b, f)) begin
            m_err = 1;
            return 0;
        end
        m_cnt   = (m_cnt == 8'hff) ? 8'hff : m_cnt + 1;
        m_chain = 1;
        m_err   = 0;
        return 1;
    endfunction

    task automatic verify(input string name);
        chk({name, ".num1"}, num1, m_n1);
        chk({name, ".num2"}, num2, m_n2);
        chk({name, ".func"}, func, m_f);
        chk({name, ".op_count"}, op_count, m_cnt);
        chk({name, ".chain"}, chain, m_chain);
        chk({name, ".err"}, err, m_err);
        chk({name, ".busy"}, busy, 0);
    endtask

    // hold the button for `hold` cycles, scramble switches after a strobe, release and settle
    task automatic press(input logic [7:0] a, b, input logic [2:0] f, input int hold,
                         output int ns, output int first);
        sw_num1 = a; sw_num2 = b; sw_func = f; btn_raw = 1;
        ns = 0; first = 0;
        for (int i = 1; i <= hold + 12; i++) begin
            if (i == hold + 1) btn_raw = 0;
            tick();
            if (calc_button) begin
                ns++;
                if (first == 0) first = i;
                sw_num1 = 8'($urandom); sw_num2 = 8'($urandom); sw_func = 3'($urandom);
            end
        end
    endtask

    initial begin
        int ns, first, nr, e;
        logic [7:0] a, b;
        logic [2:0] f;

        tbl[0] = '{8'h12, 8'h03, 3'd0, 1, 1'b0, 1};
        tbl[1] = '{8'h55, 8'h00, 3'd3, 0, 1'b1, 1};
        tbl[2] = '{8'h40, 8'h01, 3'd0, 1, 1'b0, 2};
        tbl[3] = '{8'h07, 8'h00, 3'd4, 0, 1'b1, 2};
        tbl[4] = '{8'h09, 8'h00, 3'd2, 1, 1'b0, 3};
        tbl[5] = '{8'haa, 8'hbb, 3'd6, 0, 1'b1, 3};
        tbl[6] = '{8'h01, 8'h02, 3'd7, 0, 1'b1, 3};
        tbl[7] = '{8'hff, 8'h01, 3'd4, 1, 1'b0, 4};
        tbl[8] = '{8'h10, 8'h00, 3'd5, 1, 1'b0, 5};
        tbl[9] = '{8'h33, 8'h44, 3'd6, 0, 1'b1, 5};

        model_reset();
        repeat (3) tick();
        verify("reset");
        chk("reset.calc_button", calc_button, 0);
        chk("reset.calc_rst", calc_rst, 0);
        rst = 0;
        tick();

        for (int i = 0; i < 10; i++) begin
            press(tbl[i].n1, tbl[i].n2, tbl[i].f, (i == 0) ? 20 : 12 + 4 * i, ns, first);
            e = model_press(tbl[i].n1, tbl[i].n2, tbl[i].f);
            chk($sformatf("tbl%0d.strobes", i), ns, tbl[i].ns);
            chk($sformatf("tbl%0d.model", i), e, tbl[i].ns);
            chk($sformatf("tbl%0d.err", i), err, tbl[i].err);
            chk($sformatf("tbl%0d.op_count", i), op_count, tbl[i].cnt);
            if (tbl[i].ns == 1) chk($sformatf("tbl%0d.latency", i), first, 1 + LAT);
            verify($sformatf("tbl%0d", i));
        end

        // bounce: btn_raw 1,0,1,0 two cycles each, never long enough to qualify
        ns = 0;
        for (int i = 0; i < 24; i++) begin
            btn_raw = (i < 8) && ((i / 2) % 2 == 0);
            tick();
            if (calc_button) ns++;
        end
        chk("bounce.strobes", ns, 0);
        verify("bounce");

        // async reset mid-PRESS_DB with op_count=5, err=1: outputs clear without a clock edge
        btn_raw = 1;
        repeat (5) tick();
        chk("arst.pre_busy", busy, 1);
        #2 rst = 1;
        #1;
        model_reset();
        verify("arst");
        chk("arst.calc_rst", calc_rst, 0);
        btn_raw = 0;
        repeat (2) tick();
        rst = 0;
        tick();
        press(8'h21, 8'h02, 3'd1, 15, ns, first);
        chk("arst.next.strobes", ns, model_press(8'h21, 8'h02, 3'd1));
        chk("arst.next.op_count", op_count, 1);
        verify("arst.next");

        // clr held 5 cycles, first sampled in CHECK: no strobe, one calc_rst pulse
        sw_num1 = m_n1; sw_num2 = m_n2; sw_func = m_f; btn_raw = 1;
        ns = 0; nr = 0;
        repeat (LAT) tick();
        clr = 1;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) clr = 0;
            tick();
            if (calc_button) ns++;
            if (calc_rst) nr++;
        end
        btn_raw = 0;
        repeat (12) tick();
        m_cnt = 0; m_chain = 0; m_err = 0;
        chk("clr.strobes", ns, 0);
        chk("clr.calc_rst_cycles", nr, 1);
        verify("clr");

        // random presses and idle clears against the transaction model
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                clr = 1;
                nr = 0;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    clr = 0;
                    if (calc_rst) nr++;
                end
                m_cnt = 0; m_chain = 0; m_err = 0;
                chk($sformatf("rnd%0d.calc_rst_cycles", k), nr, 1);
            end else begin
                a = 8'($urandom);
                b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                f = 3'($urandom);
                press(a, b, f, $urandom_range(10, 40), ns, first);
                e = model_press(a, b, f);
                chk($sformatf("rnd%0d.strobes", k), ns, e);
                if (e == 1) chk($sformatf("rnd%0d.latency", k), first, 1 + LAT);
            end
            verify($sformatf("rnd%0d", k));
        end

        // op_count saturation at 255
        clr = 1;
        tick();
        clr = 0;
        repeat (10) tick();
        m_cnt = 0; m_chain = 0; m_err = 0;
        for (int k = 0; k < 258; k++) begin
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            press(a, b, 3'd0, 10, ns, first);
            chk($sformatf("sat%0d.strobes", k), ns, model_press(a, b, 3'd0));
        end
        chk("sat.op_count", op_count, 8'hff);
        verify("sat");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
